vx_ibuffer_stage: RTL and testbench
===================================

// Module: vx_ibuffer_stage
// PURPOSE
//  Per-warp instruction buffer directly downstream of the decode stage; consumes the VX_decode_if bundle.
//  Queues decoded instructions in one FIFO per warp; program order is preserved within each warp.
//  Emits one instruction per cycle to the scoreboard/issue stage through a registered output.
//  Warps with pending entries are selected round-robin.
// PARAMETERS
//  NUM_WARPS  4  number of warp queues (= 2**`NW_BITS)
//  IBUF_SIZE  4  entries per warp queue; power of two, >= 2
// PORTS
//  clk        in   1   clock
//  reset      in   1   synchronous, active-high reset
//  decode_if  VX_decode_if.slave   -  decoded instruction in (valid/ready + all payload fields)
//  ibuf_if    VX_decode_if.master  -  buffered instruction out to issue (same field set)
//  wfull      out  NUM_WARPS  per-warp queue-full flags (to warp scheduler for fetch throttling)
// BEHAVIOUR
//  Payload = {uuid,wid,tmask,PC,ex_type,op_type,op_mod,wb,use_PC,use_imm,imm,rd,rs1,rs2,rs3}.
//  Payload travels unmodified.
//  Input:
//  - decode_if.ready = !full[decode_if.wid]. Combinational, independent of decode_if.valid and of any same-cycle pop.
//  - Push on clk edge when valid && ready; entry is written at the tail of queue decode_if.wid.
//  Queue state:
//  - count[w] is 0..IBUF_SIZE.
//  - full[w] = (count==IBUF_SIZE); empty[w] = (count==0); wfull = full vector, registered.
//  - Pointers wrap modulo IBUF_SIZE.
//  - Push and pop on the same warp in the same cycle: count unchanged, both pointers advance.
//  - A push into a full queue is never accepted, even with a same-cycle pop.
//  Output register (ibuf_if.valid/payload):
//  - Holds its value while valid && !ready.
//  - Loads when (!valid || ready) and a candidate exists.
//  - Candidate = first non-empty warp scanning from rr_ptr upward, wrapping past NUM_WARPS-1 to 0.
//  - On load: pop the selected head, set valid=1, and set rr_ptr = selected+1 (mod NUM_WARPS).
//  - When (!valid || ready) and no candidate: valid<=0 and the payload holds.
//  - Invariant: at most one pop per cycle; the output register never holds two instructions of the same warp out of order.
//  Latency (no bypass):
//  - An instruction accepted at edge N can appear on ibuf_if at the earliest after edge N+1.
//  - Sustained throughput is 1 instr/cycle while any queue is non-empty and ibuf_if.ready=1.
//  Reset:
//  - All counts and pointers 0; rr_ptr=0; ibuf_if.valid=0; payload=0; wfull=0.
//  - decode_if.ready=1 during and immediately after reset.
//  - Reset mid-operation discards all queued and registered instructions with no pop/push side effects.
//  Boundaries:
//  - All queues empty -> ibuf_if.valid drops the cycle after the last handshake.
//  - Warp-ID aliasing is impossible (wid width = `NW_BITS).
// CONFIGURATION
//  IBUF_BYPASS_EN defined:
//  - An accepted instruction loads directly into the output register at edge N, visible after edge N (latency 1).
//  - Conditions: all queues are empty, and the output register is free (!valid || ready).
//  - In that case the instruction is not written into its queue and rr_ptr = wid+1.
//  - Otherwise the behaviour is identical to the non-bypass path.
//  IBUF_BYPASS_EN undefined:
//  - No bypass path; minimum latency is 2 edges, as described above.
// TESTING
//  1. Reset, then push wid=1 PC=0x80000000, ready=1.
//     -> ibuf_if.valid with PC=0x80000000 after edge N+1 (N+0 with IBUF_BYPASS_EN).
//  2. ibuf_if.ready=0; push 4x wid=2 (PC 0x100..0x10C).
//     -> wfull[2]=1, decode_if.ready=0 for wid=2 and 1 for wid=0.
//     -> Then ready=1: PCs out in order 0x100,0x104,0x108,0x10C.
//  3. Queues w0,w1,w3 each hold 2 entries; ready=1.
//     -> Output wid sequence 0,1,3,0,1,3, then valid=0.
//  4. Full queue wid=0, ibuf_if.ready=1 with the head popping, push wid=0 in the same cycle.
//     -> Push rejected (ready=0); count goes 4->3.
//  5. Stall with ibuf_if.ready=0 for 5 cycles while valid.
//     -> Payload and valid stable; no pops; rr_ptr unchanged.
//  6. Assert reset with 3 warps partially filled and valid=1.
//     -> Next cycle valid=0, wfull=0, decode_if.ready=1; no stale entries ever emitted.

Source files
------------

// File: rtl/vx_ibuffer_stage.sv
// ---------------------------------------------------------------------------
// vx_ibuffer_stage
//
// Per-warp instruction buffer that sits between decode and the
// scoreboard/issue stage. Each warp has its own small FIFO, so program order
// is kept within a warp. A registered output slot feeds issue with one
// instruction per cycle. Warps with pending work are picked round-robin.
//
// Configuration macros:
//   NW_BITS         warp-id width (defaults to 2, giving 4 warps)
//   IBUF_BYPASS_EN  when defined, an instruction arriving while every queue
//                   is empty and the output slot is free skips its queue and
//                   loads straight into the output register (latency 1).
//                   When undefined, every instruction goes through its queue
//                   (minimum latency 2 edges).
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   decode_valid/ready  handshake from decode; ready = !full[decode_wid]
//   decode_*          instruction payload from decode
//   ibuf_valid/ready  handshake to issue
//   ibuf_*            registered instruction payload to issue
//   wfull             registered per-warp queue-full flags for fetch throttling
// ---------------------------------------------------------------------------
`ifndef NW_BITS
`define NW_BITS 2
`endif

module vx_ibuffer_stage #(
  parameter int IBUF_SIZE   = 4,
  parameter int NUM_THREADS = 4,
  parameter int UUID_WIDTH  = 44,
  parameter int EX_BITS     = 2,
  parameter int OP_BITS     = 4,
  parameter int MOD_BITS    = 3,
  parameter int NR_BITS     = 5
) (
  input  logic                        clk,
  input  logic                        reset,

  input  logic                        decode_valid,
  output logic                        decode_ready,
  input  logic [UUID_WIDTH-1:0]       decode_uuid,
  input  logic [`NW_BITS-1:0]         decode_wid,
  input  logic [NUM_THREADS-1:0]      decode_tmask,
  input  logic [31:0]                 decode_pc,
  input  logic [EX_BITS-1:0]          decode_ex_type,
  input  logic [OP_BITS-1:0]          decode_op_type,
  input  logic [MOD_BITS-1:0]         decode_op_mod,
  input  logic                        decode_wb,
  input  logic                        decode_use_pc,
  input  logic                        decode_use_imm,
  input  logic [31:0]                 decode_imm,
  input  logic [NR_BITS-1:0]          decode_rd,
  input  logic [NR_BITS-1:0]          decode_rs1,
  input  logic [NR_BITS-1:0]          decode_rs2,
  input  logic [NR_BITS-1:0]          decode_rs3,

  output logic                        ibuf_valid,
  input  logic                        ibuf_ready,
  output logic [UUID_WIDTH-1:0]       ibuf_uuid,
  output logic [`NW_BITS-1:0]         ibuf_wid,
  output logic [NUM_THREADS-1:0]      ibuf_tmask,
  output logic [31:0]                 ibuf_pc,
  output logic [EX_BITS-1:0]          ibuf_ex_type,
  output logic [OP_BITS-1:0]          ibuf_op_type,
  output logic [MOD_BITS-1:0]         ibuf_op_mod,
  output logic                        ibuf_wb,
  output logic                        ibuf_use_pc,
  output logic                        ibuf_use_imm,
  output logic [31:0]                 ibuf_imm,
  output logic [NR_BITS-1:0]          ibuf_rd,
  output logic [NR_BITS-1:0]          ibuf_rs1,
  output logic [NR_BITS-1:0]          ibuf_rs2,
  output logic [NR_BITS-1:0]          ibuf_rs3,

  output logic [(1 << `NW_BITS)-1:0]  wfull
);

  localparam int NW_BITS   = `NW_BITS;
  localparam int NUM_WARPS = 1 << NW_BITS;
  localparam int PTR_W     = $clog2(IBUF_SIZE);
  localparam int CNT_W     = PTR_W + 1;

  typedef struct packed {
    logic [UUID_WIDTH-1:0]  uuid;
    logic [NW_BITS-1:0]     wid;
    logic [NUM_THREADS-1:0] tmask;
    logic [31:0]            pc;
    logic [EX_BITS-1:0]     ex_type;
    logic [OP_BITS-1:0]     op_type;
    logic [MOD_BITS-1:0]    op_mod;
    logic                   wb;
    logic                   use_pc;
    logic                   use_imm;
    logic [31:0]            imm;
    logic [NR_BITS-1:0]     rd;
    logic [NR_BITS-1:0]     rs1;
    logic [NR_BITS-1:0]     rs2;
    logic [NR_BITS-1:0]     rs3;
  } payload_t;

  payload_t               mem [NUM_WARPS][IBUF_SIZE];
  logic [PTR_W-1:0]       wr_ptr   [NUM_WARPS];
  logic [PTR_W-1:0]       rd_ptr   [NUM_WARPS];
  logic [CNT_W-1:0]       count    [NUM_WARPS];
  logic [CNT_W-1:0]       cnt_next [NUM_WARPS];

  logic [NUM_WARPS-1:0]   full;
  logic [NUM_WARPS-1:0]   empty;
  logic [NUM_WARPS-1:0]   push_w;
  logic [NUM_WARPS-1:0]   pop_w;

  logic [NW_BITS-1:0]     rr_ptr;
  logic [NW_BITS-1:0]     probe;
  logic [NW_BITS-1:0]     sel;
  logic                   found;

  payload_t               in_payload;
  payload_t               out_q;
  logic                   out_valid;
  logic                   out_free;
  logic                   push;
  logic                   pop;
  logic                   bypass;
  logic                   queue_wr;

  assign in_payload = '{
    uuid:    decode_uuid,
    wid:     decode_wid,
    tmask:   decode_tmask,
    pc:      decode_pc,
    ex_type: decode_ex_type,
    op_type: decode_op_type,
    op_mod:  decode_op_mod,
    wb:      decode_wb,
    use_pc:  decode_use_pc,
    use_imm: decode_use_imm,
    imm:     decode_imm,
    rd:      decode_rd,
    rs1:     decode_rs1,
    rs2:     decode_rs2,
    rs3:     decode_rs3
  };

  // Queue status flags, derived from the occupancy counters.
  always_comb begin
    full  = '0;
    empty = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      full[w]  = (count[w] == CNT_W'(IBUF_SIZE));
      empty[w] = (count[w] == '0);
    end
  end

  // Ready depends only on the target queue's current occupancy; a pop in the
  // same cycle does not open a slot, which keeps ready free of any path from
  // ibuf_ready.
  assign decode_ready = !full[decode_wid];
  assign push         = decode_valid && decode_ready;
  assign out_free     = !out_valid || ibuf_ready;

  // Round-robin pick: first non-empty warp at or after rr_ptr. The probe
  // index is NW_BITS wide, so the addition wraps past the last warp to 0.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    probe = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      probe = rr_ptr + NW_BITS'(i);
      if (!found && !empty[probe]) begin
        found = 1'b1;
        sel   = probe;
      end
    end
  end

`ifdef IBUF_BYPASS_EN
  // Bypass only when nothing is queued anywhere, so it can never overtake an
  // older instruction of the same warp, and never coincides with a pop.
  logic all_empty;
  assign all_empty = &empty;
  assign bypass    = push && all_empty && out_free;
`else
  assign bypass    = 1'b0;
`endif

  assign pop      = out_free && found;
  assign queue_wr = push && !bypass;

  // Per-warp push/pop strobes and the resulting next occupancy.
  always_comb begin
    push_w = '0;
    pop_w  = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      push_w[w]   = queue_wr && (decode_wid == NW_BITS'(w));
      pop_w[w]    = pop && (sel == NW_BITS'(w));
      cnt_next[w] = count[w] + CNT_W'(push_w[w]) - CNT_W'(pop_w[w]);
    end
  end

  // Queue storage has no reset; validity is tracked by the counters alone.
  always_ff @(posedge clk) begin
    if (!reset && queue_wr) begin
      mem[decode_wid][wr_ptr[decode_wid]] <= in_payload;
    end
  end

  // Queue pointers, counters and the registered full flags. wfull is taken
  // from the next-state counts so it lines up with the counters themselves.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        count[w]  <= '0;
        wr_ptr[w] <= '0;
        rd_ptr[w] <= '0;
      end
      wfull <= '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        count[w] <= cnt_next[w];
        if (push_w[w]) begin
          wr_ptr[w] <= wr_ptr[w] + PTR_W'(1);
        end
        if (pop_w[w]) begin
          rd_ptr[w] <= rd_ptr[w] + PTR_W'(1);
        end
        wfull[w] <= (cnt_next[w] == CNT_W'(IBUF_SIZE));
      end
    end
  end

  // Output slot: holds while stalled, otherwise loads the bypassed or
  // selected instruction and advances the round-robin pointer past it.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_q     <= '0;
      rr_ptr    <= '0;
    end else if (out_free) begin
      if (bypass) begin
        out_valid <= 1'b1;
        out_q     <= in_payload;
        rr_ptr    <= decode_wid + NW_BITS'(1);
      end else if (found) begin
        out_valid <= 1'b1;
        out_q     <= mem[sel][rd_ptr[sel]];
        rr_ptr    <= sel + NW_BITS'(1);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  assign ibuf_valid   = out_valid;
  assign ibuf_uuid    = out_q.uuid;
  assign ibuf_wid     = out_q.wid;
  assign ibuf_tmask   = out_q.tmask;
  assign ibuf_pc      = out_q.pc;
  assign ibuf_ex_type = out_q.ex_type;
  assign ibuf_op_type = out_q.op_type;
  assign ibuf_op_mod  = out_q.op_mod;
  assign ibuf_wb      = out_q.wb;
  assign ibuf_use_pc  = out_q.use_pc;
  assign ibuf_use_imm = out_q.use_imm;
  assign ibuf_imm     = out_q.imm;
  assign ibuf_rd      = out_q.rd;
  assign ibuf_rs1     = out_q.rs1;
  assign ibuf_rs2     = out_q.rs2;
  assign ibuf_rs3     = out_q.rs3;

endmodule

// File: tb/tb_vx_ibuffer_stage.sv
// ---------------------------------------------------------------------------
// tb_vx_ibuffer_stage
//
// Directed bench for vx_ibuffer_stage (4 warps, 4-entry queues). Inputs are
// driven and outputs sampled 1ns after the rising edge. Each payload field is
// derived from the PC so output integrity can be checked from the PC alone.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_vx_ibuffer_stage;

`ifdef IBUF_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        decode_valid = 1'b0;
  logic        decode_ready;
  logic [43:0] decode_uuid = '0;
  logic [1:0]  decode_wid = '0;
  logic [3:0]  decode_tmask = '0;
  logic [31:0] decode_pc = '0;
  logic [1:0]  decode_ex_type = '0;
  logic [3:0]  decode_op_type = '0;
  logic [2:0]  decode_op_mod = '0;
  logic        decode_wb = 1'b0;
  logic        decode_use_pc = 1'b0;
  logic        decode_use_imm = 1'b0;
  logic [31:0] decode_imm = '0;
  logic [4:0]  decode_rd = '0;
  logic [4:0]  decode_rs1 = '0;
  logic [4:0]  decode_rs2 = '0;
  logic [4:0]  decode_rs3 = '0;

  logic        ibuf_valid;
  logic        ibuf_ready = 1'b0;
  logic [43:0] ibuf_uuid;
  logic [1:0]  ibuf_wid;
  logic [3:0]  ibuf_tmask;
  logic [31:0] ibuf_pc;
  logic [1:0]  ibuf_ex_type;
  logic [3:0]  ibuf_op_type;
  logic [2:0]  ibuf_op_mod;
  logic        ibuf_wb;
  logic        ibuf_use_pc;
  logic        ibuf_use_imm;
  logic [31:0] ibuf_imm;
  logic [4:0]  ibuf_rd;
  logic [4:0]  ibuf_rs1;
  logic [4:0]  ibuf_rs2;
  logic [4:0]  ibuf_rs3;
  logic [3:0]  wfull;

  int vectors = 0;
  int miscompares = 0;

  vx_ibuffer_stage dut (
    .clk            (clk),
    .reset          (reset),
    .decode_valid   (decode_valid),
    .decode_ready   (decode_ready),
    .decode_uuid    (decode_uuid),
    .decode_wid     (decode_wid),
    .decode_tmask   (decode_tmask),
    .decode_pc      (decode_pc),
    .decode_ex_type (decode_ex_type),
    .decode_op_type (decode_op_type),
    .decode_op_mod  (decode_op_mod),
    .decode_wb      (decode_wb),
    .decode_use_pc  (decode_use_pc),
    .decode_use_imm (decode_use_imm),
    .decode_imm     (decode_imm),
    .decode_rd      (decode_rd),
    .decode_rs1     (decode_rs1),
    .decode_rs2     (decode_rs2),
    .decode_rs3     (decode_rs3),
    .ibuf_valid     (ibuf_valid),
    .ibuf_ready     (ibuf_ready),
    .ibuf_uuid      (ibuf_uuid),
    .ibuf_wid       (ibuf_wid),
    .ibuf_tmask     (ibuf_tmask),
    .ibuf_pc        (ibuf_pc),
    .ibuf_ex_type   (ibuf_ex_type),
    .ibuf_op_type   (ibuf_op_type),
    .ibuf_op_mod    (ibuf_op_mod),
    .ibuf_wb        (ibuf_wb),
    .ibuf_use_pc    (ibuf_use_pc),
    .ibuf_use_imm   (ibuf_use_imm),
    .ibuf_imm       (ibuf_imm),
    .ibuf_rd        (ibuf_rd),
    .ibuf_rs1       (ibuf_rs1),
    .ibuf_rs2       (ibuf_rs2),
    .ibuf_rs3       (ibuf_rs3),
    .wfull          (wfull)
  );

  always #5 clk = ~clk;

  // Hard time limit so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    decode_valid = 1'b0;
    ibuf_ready   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Payload fields are fixed functions of wid/pc.
  task automatic drive_push(input logic [1:0] wid, input logic [31:0] pc);
    decode_valid   = 1'b1;
    decode_wid     = wid;
    decode_pc      = pc;
    decode_uuid    = {12'h0, pc};
    decode_tmask   = 4'b0001 << wid;
    decode_ex_type = pc[3:2];
    decode_op_type = pc[7:4];
    decode_op_mod  = pc[10:8];
    decode_wb      = pc[2];
    decode_use_pc  = pc[3];
    decode_use_imm = 1'b1;
    decode_imm     = ~pc;
    decode_rd      = pc[6:2];
    decode_rs1     = pc[11:7];
    decode_rs2     = 5'd2;
    decode_rs3     = 5'd3;
  endtask

  task automatic test_reset();
    do_reset();
    for (int w = 0; w < 4; w++) begin
      decode_wid = 2'(w);
      #1;
      vectors++;
      if (decode_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL reset_ready wid%0d: got %b expected 1", w, decode_ready);
      end
    end
    vectors++;
    if (ibuf_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_valid: got %b expected 0", ibuf_valid);
    end
    vectors++;
    if (wfull !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_wfull: got %b expected 0000", wfull);
    end
    vectors++;
    if (ibuf_pc !== 32'h0 || ibuf_uuid !== 44'h0 || ibuf_imm !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_payload: got pc=%h uuid=%h imm=%h expected 0", ibuf_pc, ibuf_uuid, ibuf_imm);
    end
  endtask

  task automatic test_single();
    do_reset();
    ibuf_ready = 1'b1;
    drive_push(2'd1, 32'h8000_0000);
    #1;
    vectors++;
    if (decode_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL single_ready: got %b expected 1", decode_ready);
    end
    tick();
    decode_valid = 1'b0;
`ifndef IBUF_BYPASS_EN
    vectors++;
    if (ibuf_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_early: got valid=%b expected 0", ibuf_valid);
    end
    tick();
`endif
    vectors++;
    if (ibuf_valid !== 1'b1 || ibuf_pc !== 32'h8000_0000 || ibuf_wid !== 2'd1) begin
      miscompares++;
      $display("[TB] FAIL single_out: got v=%b wid=%0d pc=%h expected v=1 wid=1 pc=80000000", ibuf_valid, ibuf_wid, ibuf_pc);
    end
    vectors++;
    if (ibuf_imm !== 32'h7FFF_FFFF || ibuf_uuid !== 44'h0_8000_0000 || ibuf_tmask !== 4'b0010 || ibuf_rd !== 5'd0 || ibuf_rs3 !== 5'd3 || ibuf_use_imm !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL single_fields: got imm=%h uuid=%h tmask=%b rd=%0d rs3=%0d expected imm=7fffffff uuid=80000000 tmask=0010 rd=0 rs3=3", ibuf_imm, ibuf_uuid, ibuf_tmask, ibuf_rd, ibuf_rs3);
    end
    tick();
    vectors++;
    if (ibuf_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_drain: got valid=%b expected 0", ibuf_valid);
    end
  endtask

  task automatic test_full();
    logic [1:0]  exp_wid [5] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2};
    logic [31:0] exp_pc  [5] = '{32'h50, 32'h100, 32'h104, 32'h108, 32'h10C};
    do_reset();
    drive_push(2'd1, 32'h50);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive_push(2'd2, 32'h100 + 32'(4 * k));
      #1;
      vectors++;
      if (decode_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL full_fill_ready k%0d: got %b expected 1", k, decode_ready);
      end
      tick();
    end
    decode_valid = 1'b0;
    decode_wid   = 2'd2;
    #1;
    vectors++;
    if (decode_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL full_ready_w2: got %b expected 0", decode_ready);
    end
    vectors++;
    if (wfull !== 4'b0100) begin
      miscompares++;
      $display("[TB] FAIL full_wfull: got %b expected 0100", wfull);
    end
    decode_wid = 2'd0;
    #1;
    vectors++;
    if (decode_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL full_ready_w0: got %b expected 1", decode_ready);
    end
    ibuf_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      vectors++;
      if (ibuf_valid !== 1'b1 || ibuf_wid !== exp_wid[j] || ibuf_pc !== exp_pc[j]) begin
        miscompares++;
        $display("[TB] FAIL full_order %0d: got v=%b wid=%0d pc=%h expected v=1 wid=%0d pc=%h", j, ibuf_valid, ibuf_wid, ibuf_pc, exp_wid[j], exp_pc[j]);
      end
      tick();
    end
    vectors++;
    if (ibuf_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL full_drain: got valid=%b expected 0", ibuf_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]  in_wid  [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd3, 2'd3};
    logic [31:0] in_pc   [6] = '{32'h200, 32'h204, 32'h300, 32'h304, 32'h400, 32'h404};
    logic [1:0]  exp_wid [6] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
    logic [31:0] exp_pc  [6] = '{32'h200, 32'h300, 32'h400, 32'h204, 32'h304, 32'h404};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive_push(in_wid[k], in_pc[k]);
      tick();
    end
    decode_valid = 1'b0;
    ibuf_ready   = 1'b1;
    for (int j = 0; j < 6; j++) begin
      vectors++;
      if (ibuf_valid !== 1'b1 || ibuf_wid !== exp_wid[j] || ibuf_pc !== exp_pc[j]) begin
        miscompares++;
        $display("[TB] FAIL rr_order %0d: got v=%b wid=%0d pc=%h expected v=1 wid=%0d pc=%h", j, ibuf_valid, ibuf_wid, ibuf_pc, exp_wid[j], exp_pc[j]);
      end
      tick();
    end
    vectors++;
    if (ibuf_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rr_drain: got valid=%b expected 0", ibuf_valid);
    end
  endtask

  task automatic test_push_while_full();
    logic [31:0] exp_pc [4] = '{32'h604, 32'h608, 32'h60C, 32'h610};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive_push(2'd0, 32'h600 + 32'(4 * k));
      #1;
      vectors++;
      if (decode_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL pwf_fill_ready k%0d: got %b expected 1", k, decode_ready);
      end
      tick();
    end
    ibuf_ready = 1'b1;
    drive_push(2'd0, 32'h700);
    #1;
    vectors++;
    if (decode_ready !== 1'b0 || wfull !== 4'b0001) begin
      miscompares++;
      $display("[TB] FAIL pwf_reject: got ready=%b wfull=%b expected ready=0 wfull=0001", decode_ready, wfull);
    end
    vectors++;
    if (ibuf_valid !== 1'b1 || ibuf_pc !== 32'h600) begin
      miscompares++;
      $display("[TB] FAIL pwf_head: got v=%b pc=%h expected v=1 pc=600", ibuf_valid, ibuf_pc);
    end
    tick();
    decode_valid = 1'b0;
    #1;
    vectors++;
    if (wfull !== 4'b0000 || decode_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL pwf_count3: got wfull=%b ready=%b expected wfull=0000 ready=1", wfull, decode_ready);
    end
    for (int j = 0; j < 4; j++) begin
      vectors++;
      if (ibuf_valid !== 1'b1 || ibuf_pc !== exp_pc[j]) begin
        miscompares++;
        $display("[TB] FAIL pwf_order %0d: got v=%b pc=%h expected v=1 pc=%h", j, ibuf_valid, ibuf_pc, exp_pc[j]);
      end
      tick();
    end
    vectors++;
    if (ibuf_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL pwf_drain: got valid=%b pc=%h expected 0", ibuf_valid, ibuf_pc);
    end
  endtask

  task automatic test_stall();
    logic [1:0]  in_wid  [4] = '{2'd1, 2'd2, 2'd3, 2'd1};
    logic [31:0] in_pc   [4] = '{32'h800, 32'h900, 32'hA00, 32'h804};
    logic [31:0] exp_pc  [4] = '{32'h800, 32'h900, 32'hA00, 32'h804};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive_push(in_wid[k], in_pc[k]);
      tick();
    end
    decode_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if (ibuf_valid !== 1'b1 || ibuf_pc !== 32'h800 || ibuf_wid !== 2'd1 || ibuf_imm !== ~32'h800) begin
        miscompares++;
        $display("[TB] FAIL stall_hold c%0d: got v=%b wid=%0d pc=%h expected v=1 wid=1 pc=800", c, ibuf_valid, ibuf_wid, ibuf_pc);
      end
      tick();
    end
    ibuf_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      vectors++;
      if (ibuf_valid !== 1'b1 || ibuf_pc !== exp_pc[j]) begin
        miscompares++;
        $display("[TB] FAIL stall_order %0d: got v=%b pc=%h expected v=1 pc=%h", j, ibuf_valid, ibuf_pc, exp_pc[j]);
      end
      tick();
    end
    vectors++;
    if (ibuf_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stall_drain: got valid=%b expected 0", ibuf_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_push(2'd0, 32'hB00);
    tick();
    drive_push(2'd1, 32'hC00);
    tick();
    drive_push(2'd2, 32'hD00);
    tick();
    drive_push(2'd2, 32'hD04);
    tick();
    vectors++;
    if (ibuf_valid !== 1'b1 || ibuf_pc !== 32'hB00) begin
      miscompares++;
      $display("[TB] FAIL rmid_pre: got v=%b pc=%h expected v=1 pc=B00", ibuf_valid, ibuf_pc);
    end
    reset      = 1'b1;
    ibuf_ready = 1'b1;
    drive_push(2'd3, 32'hE00);
    tick();
    reset        = 1'b0;
    decode_valid = 1'b0;
    decode_wid   = 2'd2;
    #1;
    vectors++;
    if (ibuf_valid !== 1'b0 || wfull !== 4'b0000 || decode_ready !== 1'b1 || ibuf_pc !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL rmid_post: got v=%b wfull=%b ready=%b pc=%h expected v=0 wfull=0000 ready=1 pc=0", ibuf_valid, wfull, decode_ready, ibuf_pc);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      vectors++;
      if (ibuf_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL rmid_stale c%0d: got v=%b pc=%h expected v=0", c, ibuf_valid, ibuf_pc);
      end
    end
    drive_push(2'd2, 32'hF00);
    tick();
    decode_valid = 1'b0;
`ifndef IBUF_BYPASS_EN
    tick();
`endif
    vectors++;
    if (ibuf_valid !== 1'b1 || ibuf_pc !== 32'hF00 || ibuf_wid !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL rmid_fresh: got v=%b wid=%0d pc=%h expected v=1 wid=2 pc=F00", ibuf_valid, ibuf_wid, ibuf_pc);
    end
  endtask

  task automatic test_back_to_back();
    int idx;
    do_reset();
    ibuf_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c < 6) begin
        drive_push(2'd0, 32'h1000 + 32'(4 * c));
      end else begin
        decode_valid = 1'b0;
      end
      #1;
      if (c < 6) begin
        vectors++;
        if (decode_ready !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL b2b_ready c%0d: got %b expected 1", c, decode_ready);
        end
      end
      idx = c - LAT;
      vectors++;
      if (idx >= 0 && idx < 6) begin
        if (ibuf_valid !== 1'b1 || ibuf_pc !== 32'h1000 + 32'(4 * idx)) begin
          miscompares++;
          $display("[TB] FAIL b2b_out c%0d: got v=%b pc=%h expected v=1 pc=%h", c, ibuf_valid, ibuf_pc, 32'h1000 + 32'(4 * idx));
        end
      end else if (ibuf_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL b2b_idle c%0d: got v=%b pc=%h expected v=0", c, ibuf_valid, ibuf_pc);
      end
      tick();
    end
  endtask

  initial begin
    $display("[TB] vx_ibuffer_stage bench start (latency %0d)", LAT);
    test_reset();
    test_single();
    test_full();
    test_round_robin();
    test_push_while_full();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
